// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, stone codes, direction indices and scan FSM states.
package board_pkg;
  localparam int BRD_SIZE   = 19;
  localparam int WIN_LEN    = 6;
  localparam int SCAN_DEPTH = WIN_LEN - 1;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P1    = 2'd1;
  localparam logic [1:0] P2    = 2'd2;
  typedef enum logic [1:0] {DIR_V, DIR_H, DIR_NE, DIR_NW} dir_e;
  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, CHECK, DONE} state_e;
  typedef enum logic {POS, NEG} phase_e;
  function automatic logic in_rng(input logic signed [5:0] v);
    return !v[5] && v[4:0] < 5'(BRD_SIZE);
  endfunction
endpackage

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: four directional probe addresses at offset k; off-board probes fall back to (x,y).
module scan_addr_gen
  import board_pkg::*;
(
  input  logic [4:0]       x,
  input  logic [4:0]       y,
  input  logic [2:0]       k,
  input  phase_e           phase,
  output logic [3:0][4:0]  ax,
  output logic [3:0][4:0]  ay,
  output logic [3:0]       inb
);
  logic signed [5:0] sx, sy, dk;
  logic signed [5:0] tx [4];
  logic signed [5:0] ty [4];
  always_comb begin
    sx = $signed({1'b0, x});
    sy = $signed({1'b0, y});
    dk = phase == NEG ? -$signed({3'b0, k}) : $signed({3'b0, k});
    tx[DIR_V]  = sx;
    ty[DIR_V]  = sy + dk;
    tx[DIR_H]  = sx + dk;
    ty[DIR_H]  = sy;
    tx[DIR_NE] = sx + dk;
    ty[DIR_NE] = sy - dk;
    tx[DIR_NW] = sx - dk;
    ty[DIR_NW] = sy - dk;
    for (int i = 0; i < 4; i++) begin
      inb[i] = in_rng(tx[i]) && in_rng(ty[i]);
      ax[i]  = inb[i] ? tx[i][4:0] : x;
      ay[i]  = inb[i] ? ty[i][4:0] : y;
    end
  end
endmodule

// File: rtl/move_scan_ctrl.sv
// move_scan_ctrl: writes one move into the board memory, then scans the four lines through it
// on a fixed schedule and reports whether the move completes a connect-6 line.
module move_scan_ctrl
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] x_in,
  input  logic [4:0] y_in,
  input  logic [1:0] player,
  output logic       mem_read,
  output logic       mem_write,
  output logic [4:0] mem_x,
  output logic [4:0] mem_y,
  output logic [1:0] mem_data,
  output logic [4:0] v_x,
  output logic [4:0] v_y,
  output logic [4:0] h_x,
  output logic [4:0] h_y,
  output logic [4:0] ne_x,
  output logic [4:0] ne_y,
  output logic [4:0] nw_x,
  output logic [4:0] nw_y,
  input  logic [1:0] v_d,
  input  logic [1:0] h_d,
  input  logic [1:0] ne_d,
  input  logic [1:0] nw_d,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       win,
  output logic [1:0] win_dir,
  output logic [3:0] max_len
);
  state_e          state, nxt;
  phase_e          phase;
  logic [4:0]      xq, yq;
  logic [1:0]      pq;
  logic [2:0]      k;
  logic [3:0]      alive, inb, hit;
  logic [3:0][2:0] pos_run, neg_run;
  logic [3:0][4:0] ax, ay;
  logic [3:0][1:0] d;
  logic            bad, accept, last, res_ok, rd, any;
  logic [3:0]      tot, best;
  logic [1:0]      wdir;

  assign d      = {nw_d, ne_d, h_d, v_d};
  assign bad    = x_in >= 5'(BRD_SIZE) || y_in >= 5'(BRD_SIZE) || player == EMPTY;
  assign accept = state == IDLE && start && !bad;
  assign last   = k == 3'(SCAN_DEPTH);

  scan_addr_gen u_gen (.x(xq), .y(yq), .k(k), .phase(phase), .ax(ax), .ay(ay), .inb(inb));

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? WRITE : IDLE;
      WRITE:   nxt = ISSUE;
      ISSUE:   nxt = CHECK;
      CHECK:   nxt = last && phase == NEG ? DONE : ISSUE;
      default: nxt = IDLE;
    endcase
  end

  always_comb
    for (int i = 0; i < 4; i++) hit[i] = alive[i] && inb[i] && d[i] == pq;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err     <= 1'b0;
      xq      <= '0;
      yq      <= '0;
      pq      <= '0;
      k       <= '0;
      phase   <= POS;
      alive   <= '0;
      pos_run <= '0;
      neg_run <= '0;
      res_ok  <= 1'b0;
    end else begin
      err <= state == IDLE && start && bad;
      if (accept) begin
        xq      <= x_in;
        yq      <= y_in;
        pq      <= player;
        pos_run <= '0;
        neg_run <= '0;
        res_ok  <= 1'b0;
      end
      if (state == WRITE) begin
        k     <= 3'd1;
        phase <= POS;
        alive <= '1;
      end
      if (state == CHECK) begin
        for (int i = 0; i < 4; i++) begin
          if (hit[i] && phase == POS) pos_run[i] <= pos_run[i] + 3'd1;
          if (hit[i] && phase == NEG) neg_run[i] <= neg_run[i] + 3'd1;
        end
        alive <= last ? 4'hf : hit;
        k     <= last ? 3'd1 : k + 3'd1;
        if (last) phase <= NEG;
        if (last && phase == NEG) res_ok <= 1'b1;
      end
    end

  // Lowest winning direction wins the tie, so scan from the top index down.
  always_comb begin
    tot  = '0;
    best = '0;
    any  = 1'b0;
    wdir = '0;
    for (int i = 3; i >= 0; i--) begin
      tot = 4'd1 + {1'b0, pos_run[i]} + {1'b0, neg_run[i]};
      if (tot > best) best = tot;
      if (tot >= 4'(WIN_LEN)) begin
        any  = 1'b1;
        wdir = 2'(i);
      end
    end
  end

  always_comb begin
    rd        = state == ISSUE || state == CHECK;
    busy      = state != IDLE;
    done      = state == DONE;
    mem_write = state == WRITE;
    mem_read  = state == ISSUE;
    mem_x     = mem_write ? xq : '0;
    mem_y     = mem_write ? yq : '0;
    mem_data  = mem_write ? pq : '0;
    v_x       = rd ? ax[DIR_V]  : '0;
    v_y       = rd ? ay[DIR_V]  : '0;
    h_x       = rd ? ax[DIR_H]  : '0;
    h_y       = rd ? ay[DIR_H]  : '0;
    ne_x      = rd ? ax[DIR_NE] : '0;
    ne_y      = rd ? ay[DIR_NE] : '0;
    nw_x      = rd ? ax[DIR_NW] : '0;
    nw_y      = rd ? ay[DIR_NW] : '0;
    win       = res_ok && any;
    win_dir   = res_ok ? wdir : '0;
    max_len   = res_ok ? best : '0;
  end
endmodule

// File: tb/tb_move_scan_ctrl.sv
// tb_move_scan_ctrl: directed vector table over preset boards plus hand sequences for busy-start and reset abort.
module tb_move_scan_ctrl;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [4:0] x_in = '0, y_in = '0;
  logic [1:0] player = '0;
  logic       mem_read, mem_write, busy, done, err, win;
  logic [4:0] mem_x, mem_y, v_x, v_y, h_x, h_y, ne_x, ne_y, nw_x, nw_y;
  logic [1:0] mem_data, win_dir;
  logic [3:0] max_len;
  logic [1:0] v_d = '0, h_d = '0, ne_d = '0, nw_d = '0;

  int n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0;

  logic [1:0] board [19][19];
  logic       pre_we = 1'b0, clr = 1'b0;
  logic [4:0] pre_x = '0, pre_y = '0;
  logic [1:0] pre_p = '0;

  move_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in), .player(player),
    .mem_read(mem_read), .mem_write(mem_write), .mem_x(mem_x), .mem_y(mem_y), .mem_data(mem_data),
    .v_x(v_x), .v_y(v_y), .h_x(h_x), .h_y(h_y), .ne_x(ne_x), .ne_y(ne_y), .nw_x(nw_x), .nw_y(nw_y),
    .v_d(v_d), .h_d(h_d), .ne_d(ne_d), .nw_d(nw_d),
    .busy(busy), .done(done), .err(err), .win(win), .win_dir(win_dir), .max_len(max_len)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] rd(input logic [4:0] a, input logic [4:0] b);
    return (a < 5'd19 && b < 5'd19) ? board[a][b] : 2'd0;
  endfunction

  // Board memory model: registered read data, single write port, plus bench preload/clear.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 19; i++)
        for (int j = 0; j < 19; j++) board[i][j] <= 2'd0;
    end else if (pre_we) board[pre_x][pre_y] <= pre_p;
    else if (mem_write && mem_x < 5'd19 && mem_y < 5'd19) board[mem_x][mem_y] <= mem_data;
    if (mem_read) begin
      v_d  <= rd(v_x, v_y);
      h_d  <= rd(h_x, h_y);
      ne_d <= rd(ne_x, ne_y);
      nw_d <= rd(nw_x, nw_y);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rw_exclusive", mem_read && mem_write, 0);
      if (mem_read)
        chk("addr_range", v_x <= 18 && v_y <= 18 && h_x <= 18 && h_y <= 18 &&
            ne_x <= 18 && ne_y <= 18 && nw_x <= 18 && nw_y <= 18, 1);
      if (!busy) chk("idle_addr_zero", |{v_x, v_y, h_x, h_y, ne_x, ne_y, nw_x, nw_y}, 0);
      if (mem_write) n_wr++;
      if (done) n_done++;
    end
  end

  task automatic put(input int x, input int y, input int p);
    @(negedge clk);
    pre_x = 5'(x); pre_y = 5'(y); pre_p = 2'(p); pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic setup(input int s);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    case (s)
      1: for (int i = 3; i <= 7; i++) put(i, 9, 1);
      2, 3: begin
        for (int j = 4; j <= 8; j++) put(10, j, 1);
        put(10, 3, 2);
        if (s == 3) put(10, 8, 2);
      end
      4: for (int i = 1; i <= 5; i++) put(i, 18 - i, 2);
      6: begin
        for (int i = 2; i <= 4; i++) put(i, 12, 2);
        for (int i = 6; i <= 9; i++) put(i, 12, 2);
      end
      7: for (int i = 1; i <= 5; i++) begin
        put(7, i, 1);
        put(7 - i, 6 - i, 1);
      end
      8: begin
        for (int i = 10; i <= 12; i++) put(i, i, 2);
        put(13, 13, 1);
        put(14, 14, 2);
      end
      default: ;
    endcase
  endtask

  task automatic issue(input int x, input int y, input int p);
    @(negedge clk);
    x_in = 5'(x); y_in = 5'(y); player = 2'(p); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    int         s;
    int         x, y, p;
    logic       e_err, e_win;
    logic [1:0] e_dir;
    logic [3:0] e_len;
  } vec_t;

  vec_t vt [12];
  int   lat, w0, d0;

  initial begin
    vt[0]  = '{1, 8, 9, 1,   0, 1, 2'd1, 4'd6};
    vt[1]  = '{2, 10, 9, 1,  0, 1, 2'd0, 4'd6};
    vt[2]  = '{3, 10, 9, 1,  0, 0, 2'd0, 4'd1};
    vt[3]  = '{4, 0, 18, 2,  0, 1, 2'd2, 4'd6};
    vt[4]  = '{0, 18, 0, 1,  0, 0, 2'd0, 4'd1};
    vt[5]  = '{6, 5, 12, 2,  0, 1, 2'd1, 4'd8};
    vt[6]  = '{7, 7, 6, 1,   0, 1, 2'd0, 4'd6};
    vt[7]  = '{8, 9, 9, 2,   0, 0, 2'd0, 4'd4};
    vt[8]  = '{0, 19, 5, 1,  1, 0, 2'd0, 4'd0};
    vt[9]  = '{0, 5, 19, 1,  1, 0, 2'd0, 4'd0};
    vt[10] = '{0, 3, 3, 0,   1, 0, 2'd0, 4'd0};
    vt[11] = '{0, 31, 31, 2, 1, 0, 2'd0, 4'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_win", win, 0);
    chk("rst_maxlen", max_len, 0);
    chk("rst_memrw", {mem_read, mem_write, mem_x, mem_y}, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      setup(vt[i].s);
      w0 = n_wr;
      issue(vt[i].x, vt[i].y, vt[i].p);
      if (vt[i].e_err) begin
        chk($sformatf("v%0d_err", i), err, 1);
        chk($sformatf("v%0d_err_busy", i), busy, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_err_pulse", i), err, 0);
        chk($sformatf("v%0d_err_idle", i), busy, 0);
        repeat (3) @(posedge clk);
        chk($sformatf("v%0d_err_nowrite", i), n_wr - w0, 0);
      end else begin
        chk($sformatf("v%0d_busy_start", i), busy, 1);
        chk($sformatf("v%0d_win_cleared", i), win, 0);
        wait_done(lat);
        chk($sformatf("v%0d_latency", i), lat, 21);
        chk($sformatf("v%0d_win", i), win, vt[i].e_win);
        chk($sformatf("v%0d_dir", i), win_dir, vt[i].e_dir);
        chk($sformatf("v%0d_maxlen", i), max_len, vt[i].e_len);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse", i), done, 0);
        chk($sformatf("v%0d_busy_end", i), busy, 0);
        chk($sformatf("v%0d_win_held", i), win, vt[i].e_win);
        chk($sformatf("v%0d_cell", i), board[vt[i].x][vt[i].y], vt[i].p);
        chk($sformatf("v%0d_one_write", i), n_wr - w0, 1);
      end
    end

    // Start while busy is ignored.
    setup(1);
    w0 = n_wr;
    d0 = n_done;
    issue(8, 9, 1);
    repeat (4) @(posedge clk);
    issue(0, 0, 2);
    wait_done(lat);
    chk("busy_start_latency", lat, 16);
    chk("busy_start_win", win, 1);
    chk("busy_start_dir", win_dir, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_writes", n_wr - w0, 1);
    chk("busy_start_dones", n_done - d0, 1);
    chk("busy_start_cell00", board[0][0], 0);
    chk("win_held_idle", win, 1);

    // Reset mid-scan aborts immediately.
    setup(0);
    d0 = n_done;
    issue(18, 0, 1);
    repeat (9) @(posedge clk);
    #2;
    chk("pre_reset_read", mem_read, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_read", mem_read, 0);
    chk("abort_win", win, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_err", err, 0);
    issue(18, 0, 1);
    wait_done(lat);
    chk("after_reset_latency", lat, 21);
    chk("after_reset_win", win, 0);
    chk("after_reset_maxlen", max_len, 1);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
